// File: rtl/bus_pkg.sv
// Shared types and constants for the single-initiator, three-target request router.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] T_MEM    = 2'd0;
    localparam logic [1:0] T_PERIPH = 2'd1;
    localparam logic [1:0] T_BOOT   = 2'd2;
    localparam logic [1:0] T_NONE   = 2'd3;

    localparam int          NUM_TGT      = 3;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } req_t;

    // T_NONE maps to all-zero so no target is ever selected by it.
    function automatic logic [NUM_TGT-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_TGT-1:0] oh;
        oh = '0;
        case (sel)
            T_MEM:    oh = 3'b001;
            T_PERIPH: oh = 3'b010;
            T_BOOT:   oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mux31.sv
// Plain 3:1 data mux; select values above 2 fall through to input c.
module mux31 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [1:0]   s,
    output logic [W-1:0] y
);

    always_comb begin
        y = c;
        case (s)
            2'd0:    y = a;
            2'd1:    y = b;
            default: y = c;
        endcase
    end

endmodule

// File: rtl/bus_demux13.sv
// Routes one outstanding request to one of three targets by address field and
// returns only the selected target's response, with decode-error and timeout aborts.
module bus_demux13
    import bus_pkg::*;
#(
    parameter int          SEL_LSB  = 28,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    input  logic [3:0]  i_be,
    output logic        i_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] i_rsp_rdata,
    output logic        i_rsp_err,
    output logic [2:0]  t_req_valid,
    input  logic [2:0]  t_req_ready,
    output logic [31:0] t_addr,
    output logic [31:0] t_wdata,
    output logic        t_we,
    output logic [3:0]  t_be,
    input  logic [2:0]  t_rsp_valid,
    input  logic [95:0] t_rsp_rdata
);

    state_t      state;
    logic [1:0]  sel;
    logic [7:0]  cnt;
    logic [1:0]  in_sel;
    logic [2:0]  sel_oh;
    logic        req_hs;
    logic        rsp_hit;
    logic [8:0]  cnt_nxt;
    logic        timed_out;
    logic [31:0] rsp_data;

    assign in_sel      = i_addr[SEL_LSB+1:SEL_LSB];
    assign sel_oh      = sel_onehot(sel);
    assign req_hs      = |(t_req_ready & sel_oh);
    assign rsp_hit     = |(t_rsp_valid & sel_oh);
    assign cnt_nxt     = {1'b0, cnt} + 9'd1;
    // >= rather than == so a handshake landing on the last ISSUE cycle still times out in WAIT.
    assign timed_out   = (cnt_nxt >= 9'(TIMEOUT));
    assign i_req_ready = (state == IDLE);

    mux31 #(.W(32)) u_rsp_mux (
        .a (t_rsp_rdata[31:0]),
        .b (t_rsp_rdata[63:32]),
        .c (t_rsp_rdata[95:64]),
        .s (sel),
        .y (rsp_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= T_MEM;
            cnt         <= '0;
            t_req_valid <= '0;
            t_addr      <= '0;
            t_wdata     <= '0;
            t_we        <= 1'b0;
            t_be        <= '0;
            i_rsp_valid <= 1'b0;
            i_rsp_rdata <= '0;
            i_rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        t_addr  <= i_addr;
                        t_wdata <= i_wdata;
                        t_we    <= i_we;
                        t_be    <= i_be;
                        sel     <= in_sel;
                        cnt     <= '0;
                        if (in_sel == T_NONE) begin
                            state       <= RESP;
                            i_rsp_valid <= 1'b1;
                            i_rsp_rdata <= ERR_DATA;
                            i_rsp_err   <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            t_req_valid <= sel_onehot(in_sel);
                        end
                    end
                end
                ISSUE: begin
                    if (req_hs) begin
                        t_req_valid <= '0;
                        cnt         <= cnt_nxt[7:0];
                        state       <= WAIT;
                    end else if (timed_out) begin
                        t_req_valid <= '0;
                        state       <= RESP;
                        i_rsp_valid <= 1'b1;
                        i_rsp_rdata <= ERR_DATA;
                        i_rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt[7:0];
                    end
                end
                WAIT: begin
                    // A real response beats a timeout firing in the same cycle.
                    if (rsp_hit) begin
                        state       <= RESP;
                        i_rsp_valid <= 1'b1;
                        i_rsp_rdata <= rsp_data;
                        i_rsp_err   <= 1'b0;
                    end else if (timed_out) begin
                        state       <= RESP;
                        i_rsp_valid <= 1'b1;
                        i_rsp_rdata <= ERR_DATA;
                        i_rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt[7:0];
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        i_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_demux13.sv
// Directed bench for bus_demux13: stimulus pushes expected responses, a monitor pops and compares.
module tb_bus_demux13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_we;
    logic [3:0]  i_be;
    logic        i_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] i_rsp_rdata;
    logic        i_rsp_err;
    logic [2:0]  t_req_valid;
    logic [2:0]  t_req_ready;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_we;
    logic [3:0]  t_be;
    logic [2:0]  t_rsp_valid;
    logic [95:0] t_rsp_rdata;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    bus_demux13 #(.SEL_LSB(28), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_we(i_we), .i_be(i_be),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
        .t_req_valid(t_req_valid), .t_req_ready(t_req_ready),
        .t_addr(t_addr), .t_wdata(t_wdata), .t_we(t_we), .t_be(t_be),
        .t_rsp_valid(t_rsp_valid), .t_rsp_rdata(t_rsp_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] be);
        i_req_valid = 1'b1;
        i_addr      = a;
        i_wdata     = d;
        i_we        = we;
        i_be        = be;
        tick();
        i_req_valid = 1'b0;
    endtask

    // Monitor: compare every accepted response against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && i_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {31'd0, i_rsp_valid}, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_rdata", i_rsp_rdata, e[31:0]);
                chk("rsp_err", {31'd0, i_rsp_err}, {31'd0, e[32]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_req_valid = 1'b0; i_addr = '0; i_wdata = '0; i_we = 1'b0; i_be = '0;
        i_rsp_ready = 1'b1;
        t_req_ready = '0; t_rsp_valid = '0; t_rsp_rdata = '0;
        #23;
        chk("rst_req_ready", {31'd0, i_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", i_rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, i_rsp_err}, 32'd0);
        chk("rst_t_req_valid", {29'd0, t_req_valid}, 32'd0);
        chk("rst_t_addr", t_addr, 32'd0);
        chk("rst_t_wdata", t_wdata, 32'd0);
        chk("rst_t_we_be", {27'd0, t_we, t_be}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Read routing to target 1, minimum latency
        t_req_ready = 3'b010;
        exp_q.push_back({1'b0, 32'h12345678});
        issue(32'h1000_0040, 32'h0, 1'b0, 4'hF);
        chk("rd_t_req_valid", {29'd0, t_req_valid}, 32'h2);
        chk("rd_t_addr", t_addr, 32'h1000_0040);
        chk("rd_t_we", {31'd0, t_we}, 32'd0);
        chk("rd_req_ready_busy", {31'd0, i_req_ready}, 32'd0);
        tick();
        chk("rd_t_req_dropped", {29'd0, t_req_valid}, 32'd0);
        t_rsp_valid = 3'b010;
        t_rsp_rdata[63:32] = 32'h12345678;
        tick();
        t_rsp_valid = '0;
        t_req_ready = '0;
        chk("rd_latency3", {31'd0, i_rsp_valid}, 32'd1);
        tick();
        chk("rd_back_idle", {31'd0, i_req_ready}, 32'd1);

        // Write with 5 cycles of target 0 backpressure
        exp_q.push_back({1'b0, 32'h5555AAAA});
        issue(32'h0000_0100, 32'habcdef12, 1'b1, 4'b0011);
        for (int i = 0; i < 5; i++) begin
            chk("wr_hold_valid", {29'd0, t_req_valid}, 32'h1);
            chk("wr_hold_wdata", t_wdata, 32'habcdef12);
            chk("wr_hold_we_be", {27'd0, t_we, t_be}, 32'h13);
            tick();
        end
        t_req_ready = 3'b001;
        chk("wr_ack_valid", {29'd0, t_req_valid}, 32'h1);
        tick();
        t_req_ready = '0;
        t_rsp_valid = 3'b001;
        t_rsp_rdata[31:0] = 32'h5555AAAA;
        tick();
        t_rsp_valid = '0;
        chk("wr_rsp_valid", {31'd0, i_rsp_valid}, 32'd1);
        tick();

        // Decode error
        exp_q.push_back({1'b1, 32'hDEADBEEF});
        issue(32'h3000_0000, 32'h0, 1'b0, 4'hF);
        chk("dec_t_req_valid", {29'd0, t_req_valid}, 32'd0);
        chk("dec_rsp_next", {31'd0, i_rsp_valid}, 32'd1);
        tick();
        chk("dec_t_req_valid2", {29'd0, t_req_valid}, 32'd0);
        chk("dec_back_idle", {31'd0, i_req_ready}, 32'd1);

        // Target 2 silent, target 0 noise, timeout after 8 cycles
        t_req_ready = 3'b100;
        t_rsp_rdata[31:0] = 32'hbabeface;
        exp_q.push_back({1'b1, 32'hDEADBEEF});
        issue(32'h2000_0000, 32'h0, 1'b0, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            chk("to_no_early_rsp", {31'd0, i_rsp_valid}, 32'd0);
            t_rsp_valid = (k == 3 || k == 4) ? 3'b001 : 3'b000;
            tick();
        end
        t_rsp_valid = '0;
        t_req_ready = '0;
        chk("to_rsp_valid", {31'd0, i_rsp_valid}, 32'd1);
        tick();

        // Response stall for 4 cycles
        i_rsp_ready = 1'b0;
        t_req_ready = 3'b001;
        exp_q.push_back({1'b0, 32'hCAFE0001});
        issue(32'h0000_0200, 32'h0, 1'b0, 4'hF);
        tick();
        t_req_ready = '0;
        t_rsp_valid = 3'b001;
        t_rsp_rdata[31:0] = 32'hCAFE0001;
        tick();
        t_rsp_valid = '0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {31'd0, i_rsp_valid}, 32'd1);
            chk("stall_rdata", i_rsp_rdata, 32'hCAFE0001);
            chk("stall_err", {31'd0, i_rsp_err}, 32'd0);
            chk("stall_req_ready", {31'd0, i_req_ready}, 32'd0);
            tick();
        end
        i_rsp_ready = 1'b1;
        tick();
        chk("stall_done_valid", {31'd0, i_rsp_valid}, 32'd0);
        chk("stall_done_ready", {31'd0, i_req_ready}, 32'd1);

        // Reset during WAIT, then a late response
        t_req_ready = 3'b010;
        issue(32'h1000_0000, 32'h0, 1'b0, 4'hF);
        tick();
        t_req_ready = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_t_req_valid", {29'd0, t_req_valid}, 32'd0);
        chk("rst_mid_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, i_req_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        t_rsp_valid = 3'b010;
        t_rsp_rdata[63:32] = 32'h0BAD0BAD;
        tick();
        tick();
        t_rsp_valid = '0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rsp_ignored", {31'd0, i_rsp_valid}, 32'd0);
            tick();
        end

        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
